i2c_frame_tx: RTL and testbench

//  Transmit side of the 13-byte calculator frame link: start byte, operand A, operand B, result.

---
 rtl/i2c_frame_pkg.sv | 41 ++++
 rtl/i2c_byte_issuer.sv | 45 ++++
 rtl/i2c_frame_tx.sv | 133 +++++++++++++
 tb/tb_i2c_frame_tx.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_frame_pkg.sv
// Shared constants, types and helpers for the calculator frame transmitter.
// Frame length depends on TX_CHECKSUM_EN (adds one XOR byte when defined).
package i2c_frame_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam logic [5:0] START_PREFIX   = 6'b111111;
    localparam int         FRAME_LEN_BASE = 13;

`ifdef TX_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] ACCEPT   = 3'd2;
    localparam logic [2:0] COMPLETE = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    typedef struct packed {
        logic [7:0]  start;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } frame_t;

    function automatic logic [7:0] frame_xor(input logic [103:0] frame);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < FRAME_LEN_BASE; i++) acc ^= frame[i*8 +: 8];
        return acc;
    endfunction

endpackage

// File: rtl/i2c_byte_issuer.sv
// Single-byte enable/ready handshake toward the I2C master, with the
// ACCEPT-phase timeout counter. Reports issue/accept/timeout/byte_done to the frame FSM.
module i2c_byte_issuer
    import i2c_frame_pkg::*;
#(
    parameter int ACCEPT_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       m_ready,
    output logic       m_enable,
    output logic       issue,
    output logic       accepted,
    output logic       timeout,
    output logic       byte_done
);

    localparam int            TW         = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACCEPT_TIMEOUT - 1);

    logic [TW-1:0] timer;

    // A master that drops ready wins over a timeout landing on the same cycle.
    assign issue     = (state == LOAD) && m_ready;
    assign accepted  = (state == ACCEPT) && !m_ready;
    assign timeout   = (state == ACCEPT) && m_ready && (timer == TIMER_LAST);
    assign byte_done = (state == COMPLETE) && m_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_enable <= 1'b0;
            timer    <= '0;
        end else if (issue) begin
            m_enable <= 1'b1;
            timer    <= '0;
        end else if (accepted || timeout) begin
            m_enable <= 1'b0;
        end else if (state == ACCEPT) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_frame_tx.sv
// Frame transmitter: latches {start, A, B, R} and streams it MSB-first through the master.
// Build with TX_CHECKSUM_EN defined to append an XOR checksum byte.
module i2c_frame_tx #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h07,
    parameter logic [5:0] START_PREFIX   = i2c_frame_pkg::START_PREFIX,
    parameter int         ACCEPT_TIMEOUT = 1023,
    parameter int         GAP_CYCLES     = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] result,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_data,
    output logic        m_rw,
    output logic        m_enable,
    input  logic        m_ready,
    output logic        busy,
    output logic [3:0]  byte_idx,
    output logic        done,
    output logic        error
);
    import i2c_frame_pkg::*;

    localparam int            SREG_W   = FRAME_LEN * 8;
    localparam logic [3:0]    LAST_IDX = 4'(FRAME_LEN - 1);
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]        state;
    logic [SREG_W-1:0] sreg;
    logic [GW-1:0]     gap_cnt;
    frame_t            frame;
    logic              issue, accepted, timeout, byte_done;

    always_comb begin
        frame.start = {START_PREFIX, op};
        frame.a     = op_a;
        frame.b     = op_b;
        frame.r     = result;
    end

    assign m_addr = SLAVE_ADDR;
    assign m_rw   = 1'b0;
    assign m_data = sreg[SREG_W-1 -: 8];

    i2c_byte_issuer #(
        .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)
    ) u_issuer (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .m_ready  (m_ready),
        .m_enable (m_enable),
        .issue    (issue),
        .accepted (accepted),
        .timeout  (timeout),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            // NOTE: the shift register is reset too, so m_data reads 0 right after reset.
            sreg        <= '0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            frame_ready <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_ready && frame_valid) begin
`ifdef TX_CHECKSUM_EN
                        sreg <= {frame, frame_xor(frame)};
`else
                        sreg <= frame;
`endif
                        byte_idx    <= '0;
                        busy        <= 1'b1;
                        frame_ready <= 1'b0;
                        state       <= LOAD;
                    end else begin
                        frame_ready <= 1'b1;
                    end
                end
                LOAD: if (issue) state <= ACCEPT;
                ACCEPT: begin
                    if (accepted) begin
                        state <= COMPLETE;
                    end else if (timeout) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                COMPLETE: begin
                    if (byte_done) begin
                        if (byte_idx == LAST_IDX) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            sreg     <= {sreg[SREG_W-9:0], 8'h00};
                            byte_idx <= byte_idx + 4'd1;
                            state    <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        frame_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Self-checking bench for i2c_frame_tx: behavioural master, byte-stream model, per-scenario tasks.
`timescale 1ns/1ps
module tb_i2c_frame_tx;

    localparam int ACCEPT_TIMEOUT = 1023;
    localparam int GAP_CYCLES     = 50;
`ifdef TX_CHECKSUM_EN
    localparam int FRAME_LEN = 14;
`else
    localparam int FRAME_LEN = 13;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = '0, op_b = '0, result = '0;
    logic        m_ready = 1'b1;
    logic        frame_ready, m_rw, m_enable, busy, done, error;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic [3:0]  byte_idx;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int done_cnt = 0, err_cnt = 0, en_rise_cnt = 0;
    bit stuck = 0, force_low = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];

    i2c_frame_tx #(
        .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .result     (result),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_ready    (m_ready),
        .busy       (busy),
        .byte_idx   (byte_idx),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor plus behavioural master; one process so sampling precedes the master's update.
    initial begin : master
        int         phase;
        int         lat;
        int         hold;
        logic       prev_en;
        logic [7:0] prev_data;
        phase = 0; lat = 0; hold = 0; prev_en = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (error === 1'b1) err_cnt++;
            if (m_enable === 1'b1 && !prev_en) begin
                en_rise_cnt++;
                checks++;
                if (m_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL enable_vs_ready: m_ready=%b at enable rise, required 1 (t=%0t)", m_ready, $time);
                end
            end
            if (m_enable === 1'b1 && prev_en && m_data !== prev_data) begin
                fails++;
                $display("FAIL data_stable: m_data=%h while enabled, required %h (t=%0t)", m_data, prev_data, $time);
            end
            if (frame_ready === 1'b1 && busy === 1'b1) begin
                fails++;
                $display("FAIL ready_busy_overlap: frame_ready=1 busy=1, required not both (t=%0t)", $time);
            end
            prev_en   = (m_enable === 1'b1);
            prev_data = m_data;

            if (!rst) begin
                phase   = 0;
                m_ready = !force_low;
            end else begin
                case (phase)
                    0: begin
                        if (m_enable === 1'b1 && m_ready && !stuck) begin
                            cap_q.push_back(m_data);
                            lat   = $urandom_range(0, 2);
                            phase = 1;
                        end else begin
                            m_ready = !force_low;
                        end
                    end
                    1: begin
                        if (lat == 0) begin
                            m_ready = 1'b0;
                            hold    = $urandom_range(1, 5);
                            phase   = 2;
                        end else begin
                            lat--;
                        end
                    end
                    default: begin
                        hold--;
                        if (hold == 0) begin
                            m_ready = 1'b1;
                            phase   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Reference byte stream: start byte, then each word big-endian, optional XOR byte.
    task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r);
        logic [7:0] bytes [13];
        logic [7:0] x;
        bytes[0] = {6'b111111, o};
        for (int i = 0; i < 4; i++) begin
            bytes[1 + i] = 8'((a >> (24 - 8 * i)) & 32'hFF);
            bytes[5 + i] = 8'((b >> (24 - 8 * i)) & 32'hFF);
            bytes[9 + i] = 8'((r >> (24 - 8 * i)) & 32'hFF);
        end
        x = '0;
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(bytes[i]);
            x ^= bytes[i];
        end
`ifdef TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // sel: 0 = done or error, 1 = frame_ready, 2 = busy. Expired bound counts as a failure.
    task automatic wait_for(input int sel, input string name);
        int  n;
        bit  hit;
        n = 0;
        hit = 0;
        while (!hit && n < 6000) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = (done === 1'b1) || (error === 1'b1);
                1:       hit = (frame_ready === 1'b1);
                default: hit = (busy === 1'b1);
            endcase
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL %s: condition not seen within %0d cycles, required seen", name, n);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r);
        if (frame_ready !== 1'b1) wait_for(1, "launch_ready");
        op = o; op_a = a; op_b = b; result = r;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame_ready, busy, m_enable, m_rw, done, error, byte_idx, m_data, m_addr} !==
            {6'b0, 4'h0, 8'h00, 7'h07}) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b en=%b rw=%b done=%b err=%b idx=%h data=%h addr=%h, required zeros and addr 07",
                     frame_ready, busy, m_enable, m_rw, done, error, byte_idx, m_data, m_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle_ready: frame_ready=%b required 1", frame_ready);
        end
    endtask

    task automatic test_spec_vector();
        int d0, e0;
        cap_q.delete(); exp_q.delete();
        d0 = done_cnt; e0 = err_cnt;
        push_exp(2'b10, 32'h40400000, 32'h3F000000, 32'h3FC00000);
        launch(2'b10, 32'h40400000, 32'h3F000000, 32'h3FC00000);
        wait_for(0, "spec_end");
        @(negedge clk);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL spec_len: got %0d bytes, required %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL spec_byte[%0d]: got %h required %h", i, cap_q[i], exp_q[i]);
            end
        end
        checks++;
        if (cap_q.size() > 12 && {cap_q[0], cap_q[9], cap_q[10]} !== 24'hFE3FC0) begin
            fails++;
            $display("FAIL spec_known_bytes: got %h %h %h, required FE 3F C0", cap_q[0], cap_q[9], cap_q[10]);
        end
        checks++;
        if (m_addr !== 7'h07 || m_rw !== 1'b0) begin
            fails++;
            $display("FAIL spec_addr_rw: got addr=%h rw=%b, required 07 and 0", m_addr, m_rw);
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL spec_done_count: got done=%0d err=%0d, required 1 and 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (byte_idx !== 4'(FRAME_LEN - 1)) begin
            fails++;
            $display("FAIL spec_idx_saturate: got %0d, required %0d", byte_idx, FRAME_LEN - 1);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, r;
        for (int f = 0; f < 4; f++) begin
            cap_q.delete(); exp_q.delete();
            o = 2'($urandom_range(0, 3));
            a = $urandom(); b = $urandom(); r = $urandom();
            push_exp(o, a, b, r);
            launch(o, a, b, r);
            wait_for(0, "random_end");
            @(negedge clk);
            checks++;
            if (cap_q.size() != exp_q.size() || done !== 1'b0) begin
                fails++;
                $display("FAIL random_len[%0d]: got %0d bytes, required %0d", f, cap_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random_byte[%0d][%0d]: got %h required %h", f, i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, r0, t_done, t_rdy;
        logic [31:0] a1, b1, r1, a2, b2, r2;
        cap_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = en_rise_cnt;
        a1 = $urandom(); b1 = $urandom(); r1 = $urandom();
        a2 = $urandom(); b2 = $urandom(); r2 = $urandom();
        push_exp(2'b01, a1, b1, r1);
        push_exp(2'b11, a2, b2, r2);
        if (frame_ready !== 1'b1) wait_for(1, "b2b_ready0");
        op = 2'b01; op_a = a1; op_b = b1; result = r1;
        frame_valid = 1'b1;
        wait_for(2, "b2b_busy1");
        op = 2'b11; op_a = a2; op_b = b2; result = r2;
        wait_for(0, "b2b_done1");
        t_done = cycle;
        wait_for(1, "b2b_ready1");
        t_rdy = cycle;
        checks++;
        if (t_rdy - t_done != GAP_CYCLES) begin
            fails++;
            $display("FAIL b2b_gap: frame_ready rose %0d cycles after done, required %0d", t_rdy - t_done, GAP_CYCLES);
        end
        wait_for(2, "b2b_busy2");
        frame_valid = 1'b0;
        wait_for(0, "b2b_done2");
        repeat (GAP_CYCLES + 20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2 || en_rise_cnt - r0 != 2 * FRAME_LEN) begin
            fails++;
            $display("FAIL b2b_frames: got done=%0d enables=%0d, required 2 and %0d",
                     done_cnt - d0, en_rise_cnt - r0, 2 * FRAME_LEN);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b_byte[%0d]: got %h required %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ready_low();
        int bad;
        logic [31:0] a, b, r;
        cap_q.delete(); exp_q.delete();
        force_low = 1;
        repeat (2) @(negedge clk);
        a = $urandom(); b = $urandom(); r = $urandom();
        push_exp(2'b10, a, b, r);
        launch(2'b10, a, b, r);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || busy !== 1'b1 || byte_idx !== 4'd0) begin
            fails++;
            $display("FAIL ready_low_hold: enable cycles=%0d busy=%b idx=%0d, required 0, 1, 0", bad, busy, byte_idx);
        end
        force_low = 0;
        wait_for(0, "ready_low_end");
        @(negedge clk);
        checks++;
        if (cap_q.size() == 0 || cap_q[0] !== 8'hFE) begin
            fails++;
            $display("FAIL ready_low_first: got %0d bytes first=%h, required first FE",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'h00);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL ready_low_byte[%0d]: got %h required %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int d0, e0, en_hi, n;
        d0 = done_cnt; e0 = err_cnt;
        stuck = 1;
        launch(2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom());
        en_hi = 0;
        n = 0;
        while (error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (m_enable === 1'b1) en_hi++;
        end
        checks++;
        if (error !== 1'b1 || m_enable !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: err=%b en=%b busy=%b after %0d cycles, required 1 0 0", error, m_enable, busy, n);
        end
        checks++;
        if (en_hi != ACCEPT_TIMEOUT) begin
            fails++;
            $display("FAIL timeout_cycles: m_enable high %0d cycles, required %0d", en_hi, ACCEPT_TIMEOUT);
        end
        stuck = 0;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_pulse: error=%b one cycle later, required 0", error);
        end
        wait_for(1, "timeout_idle");
        checks++;
        if (done_cnt != d0 || err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL timeout_counts: got done=%0d err=%0d, required 0 and 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int n, r0, d0, e0;
        launch(2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom());
        n = 0;
        while (byte_idx !== 4'd5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (byte_idx !== 4'd5) begin
            fails++;
            $display("FAIL rstmid_reach: byte_idx=%0d, required 5", byte_idx);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({frame_ready, busy, m_enable, m_rw, done, error, byte_idx, m_data, m_addr} !==
            {6'b0, 4'h0, 8'h00, 7'h07}) begin
            fails++;
            $display("FAIL rstmid_outputs: got rdy=%b busy=%b en=%b rw=%b done=%b err=%b idx=%h data=%h addr=%h, required zeros and addr 07",
                     frame_ready, busy, m_enable, m_rw, done, error, byte_idx, m_data, m_addr);
        end
        r0 = en_rise_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (en_rise_cnt != r0 || done_cnt != d0 || err_cnt != e0 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_quiet: enables=%0d done=%0d err=%0d rdy=%b, required 0 0 0 1",
                     en_rise_cnt - r0, done_cnt - d0, err_cnt - e0, frame_ready);
        end
    endtask

    task automatic test_checksum();
        int d0, r0;
        cap_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = en_rise_cnt;
        push_exp(2'b10, 32'h12345678, 32'h87654321, 32'hFFFFFFFF);
        launch(2'b10, 32'h12345678, 32'h87654321, 32'hFFFFFFFF);
        wait_for(0, "cksum_end");
        @(negedge clk);
        checks++;
        if (cap_q.size() != FRAME_LEN || done_cnt - d0 != 1 || en_rise_cnt - r0 != FRAME_LEN) begin
            fails++;
            $display("FAIL cksum_len: got %0d bytes done=%0d enables=%0d, required %0d 1 %0d",
                     cap_q.size(), done_cnt - d0, en_rise_cnt - r0, FRAME_LEN, FRAME_LEN);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL cksum_byte[%0d]: got %h required %h", i, cap_q[i], exp_q[i]);
            end
        end
`ifdef TX_CHECKSUM_EN
        checks++;
        if (cap_q.size() < 14 || cap_q[13] !== 8'h76) begin
            fails++;
            $display("FAIL cksum_value: got %h, required 76", (cap_q.size() >= 14) ? cap_q[13] : 8'h00);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_random();
        test_back_to_back();
        test_ready_low();
        test_timeout();
        test_reset_mid();
        test_checksum();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
